// File: rtl/traffic_led_monitor_pkg.sv
// Shared definitions for the lamp-bus monitor: LED bit positions, lamp patterns,
// phase and state codes, shadow selectors and the phase-length rule.
package traffic_led_monitor_pkg;

    localparam int LED_MR   = 0;
    localparam int LED_MY   = 1;
    localparam int LED_MG   = 2;
    localparam int LED_SR   = 3;
    localparam int LED_SY   = 4;
    localparam int LED_SG   = 5;
    localparam int LED_WALK = 6;
    localparam int LED_HB   = 7;

    // Legal lamp patterns on leds[6:0]: walk, sG, sY, sR, mG, mY, mR
    localparam logic [6:0] PAT_MG     = 7'b000_1100;
    localparam logic [6:0] PAT_MY     = 7'b000_1010;
    localparam logic [6:0] PAT_SG     = 7'b010_0001;
    localparam logic [6:0] PAT_SY     = 7'b001_0001;
    localparam logic [6:0] PAT_WALK   = 7'b100_1001;
    localparam logic [6:0] PAT_ALLRED = 7'b000_1001;

    localparam logic [1:0] SEL_BASE = 2'b00;
    localparam logic [1:0] SEL_EXT  = 2'b01;
    localparam logic [1:0] SEL_YEL  = 2'b10;
    localparam logic [1:0] SEL_WALK = 2'b11;

    typedef enum logic [2:0] {
        PH_NONE   = 3'd0,
        PH_MG     = 3'd1,
        PH_MY     = 3'd2,
        PH_SG     = 3'd3,
        PH_SY     = 3'd4,
        PH_WALK   = 3'd5,
        PH_ALLRED = 3'd6
    } phase_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    function automatic logic len_ok(input phase_e ph, input int len, input int t_base,
                                    input int t_ext, input int t_yel, input int t_walk);
        logic ok;
        ok = 1'b1;
        case (ph)
            PH_MG:         ok = (len >= t_base);
            PH_SG:         ok = (len >= t_ext);
            PH_MY, PH_SY:  ok = (len == t_yel);
            PH_WALK:       ok = (len == t_walk);
            PH_ALLRED:     ok = (len <= 2);
            default:       ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/tlm_phase_decoder.sv
// Combinational lamp decoder: maps the seven lamp bits to a phase code and
// flags every pattern that is not one of the six legal ones.
module tlm_phase_decoder
    import traffic_led_monitor_pkg::*;
(
    input  logic [6:0] leds_i,
    output phase_e     phase_o,
    output logic       illegal_o
);

    always_comb begin
        phase_o   = PH_NONE;
        illegal_o = 1'b0;
        case (leds_i)
            PAT_MG:     phase_o = PH_MG;
            PAT_MY:     phase_o = PH_MY;
            PAT_SG:     phase_o = PH_SG;
            PAT_SY:     phase_o = PH_SY;
            PAT_WALK:   phase_o = PH_WALK;
            PAT_ALLRED: phase_o = PH_ALLRED;
            default:    illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/traffic_led_monitor.sv
// Lamp-bus safety monitor: tracks controller phases, measures their length in
// ticks against shadow timing parameters, and latches lamp conflicts as FAULT.
//
//   state | meaning
//   IDLE  | waiting for first legal pattern; next phase is partial, not checked
//   TRACK | counting ticks in the current phase, checking on each change
//   FAULT | lamp conflict seen; held until clear_fault
module traffic_led_monitor
    import traffic_led_monitor_pkg::*;
#(
    parameter logic [3:0] T_BASE_DEF = 4'd6,
    parameter logic [3:0] T_EXT_DEF  = 4'd3,
    parameter logic [3:0] T_YEL_DEF  = 4'd2,
    parameter logic [3:0] T_WALK_DEF = 4'd3,
    parameter int         LEN_W      = 5
) (
    input  logic             clk,
    input  logic             g_reset,
    input  logic [7:0]       leds,
    input  logic             tick,
    input  logic             reprogram,
    input  logic [1:0]       time_parameter_selector,
    input  logic [3:0]       time_value,
    input  logic             clear_fault,
    output logic [2:0]       phase,
    output logic             phase_done,
    output logic [LEN_W-1:0] phase_len,
    output logic             timing_error,
    output logic             fault,
    output logic [7:0]       err_count
);

    phase_e             dec_phase;
    logic               dec_illegal;
    logic               unused_heartbeat;

    state_e             state_q;
    phase_e             phase_q;
    logic [LEN_W-1:0]   cnt_q;
    logic               first_q;
    logic               done_q;
    logic [LEN_W-1:0]   len_q;
    logic               terr_q;
    logic               fault_q;
    logic [7:0]         errcnt_q;
    logic               reprog_q;
    logic [3:0]         shadow_q [4];

    logic               load_d;
    logic               change_d;
    logic               len_ok_d;

    assign unused_heartbeat = leds[LED_HB];

    tlm_phase_decoder u_decoder (
        .leds_i    (leds[6:0]),
        .phase_o   (dec_phase),
        .illegal_o (dec_illegal)
    );

    assign load_d   = reprogram & ~reprog_q;
    assign change_d = (dec_phase != phase_q);
    assign len_ok_d = len_ok(phase_q, int'(cnt_q),
                             int'(shadow_q[SEL_BASE]), int'(shadow_q[SEL_EXT]),
                             int'(shadow_q[SEL_YEL]),  int'(shadow_q[SEL_WALK]));

    always_ff @(posedge clk or negedge g_reset) begin
        if (!g_reset) begin
            reprog_q           <= 1'b0;
            shadow_q[SEL_BASE] <= T_BASE_DEF;
            shadow_q[SEL_EXT]  <= T_EXT_DEF;
            shadow_q[SEL_YEL]  <= T_YEL_DEF;
            shadow_q[SEL_WALK] <= T_WALK_DEF;
        end else begin
            reprog_q <= reprogram;
            if (load_d) begin
                shadow_q[time_parameter_selector] <= time_value;
            end
        end
    end

    always_ff @(posedge clk or negedge g_reset) begin
        if (!g_reset) begin
            state_q  <= ST_IDLE;
            phase_q  <= PH_NONE;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            done_q   <= 1'b0;
            len_q    <= '0;
            terr_q   <= 1'b0;
            fault_q  <= 1'b0;
            errcnt_q <= '0;
        end else begin
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
            phase_q <= dec_phase;
            case (state_q)
                ST_IDLE: begin
                    if (dec_illegal) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                    end else begin
                        state_q <= ST_TRACK;
                        cnt_q   <= '0;
                        first_q <= 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (dec_illegal) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                    end else if (change_d) begin
                        done_q  <= 1'b1;
                        len_q   <= cnt_q;
                        first_q <= 1'b0;
                        cnt_q   <= tick ? LEN_W'(1) : '0;
                        // The phase entered from IDLE may have started before we looked.
                        if (!first_q && !len_ok_d) begin
                            terr_q <= 1'b1;
                            if (errcnt_q != 8'hFF) begin
                                errcnt_q <= errcnt_q + 8'd1;
                            end
                        end
                    end else if (tick && (cnt_q != '1)) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                    end
                end
                ST_FAULT: begin
                    if (clear_fault) begin
                        state_q <= ST_IDLE;
                        fault_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign phase        = phase_q;
    assign phase_done   = done_q;
    assign phase_len    = len_q;
    assign timing_error = terr_q;
    assign fault        = fault_q;
    assign err_count    = errcnt_q;

endmodule

// File: tb/tb_traffic_led_monitor.sv
// Directed bench for traffic_led_monitor: drives lamp patterns and ticks and
// compares the monitor's outputs against hand-computed values.
module tb_traffic_led_monitor;

    logic       clk;
    logic       g_reset;
    logic [7:0] leds;
    logic       tick;
    logic       reprogram;
    logic [1:0] time_parameter_selector;
    logic [3:0] time_value;
    logic       clear_fault;
    logic [2:0] phase;
    logic       phase_done;
    logic [4:0] phase_len;
    logic       timing_error;
    logic       fault;
    logic [7:0] err_count;

    int n_chk  = 0;
    int n_pass = 0;

    traffic_led_monitor dut (
        .clk                     (clk),
        .g_reset                 (g_reset),
        .leds                    (leds),
        .tick                    (tick),
        .reprogram               (reprogram),
        .time_parameter_selector (time_parameter_selector),
        .time_value              (time_value),
        .clear_fault             (clear_fault),
        .phase                   (phase),
        .phase_done              (phase_done),
        .phase_len               (phase_len),
        .timing_error            (timing_error),
        .fault                   (fault),
        .err_count               (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, n_chk=%0d", n_chk);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
    endtask

    // Change the lamp pattern and check the phase_done report for the phase just ended.
    task automatic chg(input logic [7:0] v, input logic tck, input int exp_ph,
                       input int exp_len, input int exp_terr);
        leds = v;
        tick = tck;
        step();
        tick = 1'b0;
        chk("chg.done",  int'(phase_done),   1);
        chk("chg.phase", int'(phase),        exp_ph);
        chk("chg.len",   int'(phase_len),    exp_len);
        chk("chg.terr",  int'(timing_error), exp_terr);
    endtask

    initial begin
        g_reset = 1'b0;
        leds = 8'h0C;
        tick = 1'b0;
        reprogram = 1'b0;
        time_parameter_selector = 2'b00;
        time_value = 4'd0;
        clear_fault = 1'b0;

        #23;
        chk("rst.phase", int'(phase),        0);
        chk("rst.done",  int'(phase_done),   0);
        chk("rst.len",   int'(phase_len),    0);
        chk("rst.terr",  int'(timing_error), 0);
        chk("rst.fault", int'(fault),        0);
        chk("rst.errc",  int'(err_count),    0);

        @(posedge clk);
        #1;
        g_reset = 1'b1;
        step();
        chk("start.phase", int'(phase), 1);
        chk("start.done",  int'(phase_done), 0);

        // Normal cycle with default shadows 6/3/2/3
        ticks(6); chg(8'h0A, 1'b0, 2, 6, 0);
        ticks(2); chg(8'h21, 1'b0, 3, 2, 0);
        ticks(3); chg(8'h11, 1'b0, 4, 3, 0);
        ticks(3); chg(8'h09, 1'b0, 6, 3, 1);
        chk("err.after_sy", int'(err_count), 1);
        ticks(1); chg(8'h0C, 1'b0, 1, 1, 0);
        ticks(7); chg(8'h0A, 1'b0, 2, 7, 0);
        ticks(3); chg(8'h21, 1'b0, 3, 3, 1);
        chk("err.after_my", int'(err_count), 2);
        ticks(2); chg(8'h11, 1'b0, 4, 2, 1);
        chk("err.after_sg", int'(err_count), 3);
        ticks(2); chg(8'h09, 1'b0, 6, 2, 0);
        ticks(3); chg(8'h49, 1'b0, 5, 3, 1);
        chk("err.after_allred", int'(err_count), 4);
        ticks(3); chg(8'h09, 1'b0, 6, 3, 0);
        ticks(1); chg(8'h0C, 1'b1, 1, 1, 0);
        ticks(5); chg(8'h0A, 1'b0, 2, 6, 0);

        // Lamp conflict mG+sG coinciding with a phase change
        leds = 8'h24;
        step();
        chk("conf.fault", int'(fault), 1);
        chk("conf.done",  int'(phase_done), 0);
        step();
        chk("conf.hold_fault", int'(fault), 1);
        chk("conf.hold_done",  int'(phase_done), 0);
        leds = 8'h0C;
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        chk("clr.fault", int'(fault), 0);
        step();
        chk("clr.phase", int'(phase), 1);
        chk("clr.fault2", int'(fault), 0);

        // Yellow reprogrammed to 4 ticks
        reprogram = 1'b1;
        time_parameter_selector = 2'b10;
        time_value = 4'd4;
        step();
        reprogram = 1'b0;
        step();
        ticks(6); chg(8'h0A, 1'b0, 2, 6, 0);
        ticks(4); chg(8'h21, 1'b0, 3, 4, 0);
        ticks(3); chg(8'h11, 1'b0, 4, 3, 0);
        ticks(2); chg(8'h09, 1'b0, 6, 2, 1);
        chk("err.after_reprog", int'(err_count), 5);

        // Walk lit together with mG
        leds = 8'h44;
        step();
        chk("walkmg.fault", int'(fault), 1);
        chk("walkmg.done",  int'(phase_done), 0);
        leds = 8'h09;
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        step();
        chk("walkmg.clr_phase", int'(phase), 6);
        chk("walkmg.clr_fault", int'(fault), 0);
        chg(8'h49, 1'b0, 5, 0, 0);
        ticks(3); chg(8'h09, 1'b0, 6, 3, 0);
        chk("err.after_walk", int'(err_count), 5);

        // Asynchronous reset mid-phase
        ticks(2);
        g_reset = 1'b0;
        #1;
        chk("arst.phase", int'(phase),        0);
        chk("arst.done",  int'(phase_done),   0);
        chk("arst.len",   int'(phase_len),    0);
        chk("arst.terr",  int'(timing_error), 0);
        chk("arst.fault", int'(fault),        0);
        chk("arst.errc",  int'(err_count),    0);
        leds = 8'h0C;
        step();
        g_reset = 1'b1;
        step();
        chk("arst.restart_phase", int'(phase), 1);
        ticks(33); chg(8'h0A, 1'b0, 2, 31, 0);
        ticks(2);  chg(8'h21, 1'b0, 3, 2, 0);
        chk("arst.errc_end", int'(err_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
